// File: rtl/lebug_pkg.sv
// Shared definitions for the chained input buffer.
//   - Default geometry and CONFIG_ID used as parameter defaults.
//   - entry_t: the record stored per queue slot (vector, EOF tag, chain tag)
//     at the default geometry.
//   - clamp_chains(): maps a raw configData byte onto [1, max_chains].
package lebug_pkg;

  localparam int          DEF_N          = 8;
  localparam int          DEF_DATA_WIDTH = 32;
  localparam int          DEF_IB_DEPTH   = 4;
  localparam int          DEF_MAX_CHAINS = 4;
  localparam logic [7:0]  DEF_CONFIG_ID  = 8'd1;

  typedef struct packed {
    logic [DEF_N*DEF_DATA_WIDTH-1:0]   vector;
    logic                              eof;
    logic [$clog2(DEF_MAX_CHAINS)-1:0] chain_id;
  } entry_t;

  function automatic int clamp_chains(input logic [7:0] raw, input int max_chains);
    if (raw == 8'd0) return 1;
    if (int'(raw) > max_chains) return max_chains;
    return int'(raw);
  endfunction

endpackage

// File: rtl/chained_input_buffer_if.sv
// Bus bundle for chained_input_buffer.
//   master: the producer/consumer side (drives enqueue, data, config, dequeue_in)
//   slave : the buffer itself (drives valid/eof/vector/chainId/full/overflow/occupancy)
interface chained_input_buffer_if
  import lebug_pkg::*;
#(
  parameter int N          = DEF_N,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int IB_DEPTH   = DEF_IB_DEPTH,
  parameter int MAX_CHAINS = DEF_MAX_CHAINS
);
  logic                            enqueue;
  logic                            eof_in;
  logic                            tracing;
  logic [7:0]                      configId;
  logic [7:0]                      configData;
  logic [N*DATA_WIDTH-1:0]         vector_in;
  logic                            dequeue_in;
  logic                            valid_out;
  logic                            eof_out;
  logic [N*DATA_WIDTH-1:0]         vector_out;
  logic [$clog2(MAX_CHAINS)-1:0]   chainId_out;
  logic                            full_out;
  logic                            overflow_out;
  logic [$clog2(IB_DEPTH):0]       occupancy_out;

  modport master (
    output enqueue, eof_in, tracing, configId, configData, vector_in, dequeue_in,
    input  valid_out, eof_out, vector_out, chainId_out, full_out, overflow_out, occupancy_out
  );

  modport slave (
    input  enqueue, eof_in, tracing, configId, configData, vector_in, dequeue_in,
    output valid_out, eof_out, vector_out, chainId_out, full_out, overflow_out, occupancy_out
  );
endinterface

// File: rtl/ram_dual_port.sv
// Simple dual-port RAM: port A writes, port B reads with one cycle latency.
// The read register holds its value while b_re is low, which lets the
// caller park a fetched entry until the output stage can take it.
//   clk            : clock
//   a_we/a_addr/a_wdata : write port
//   b_re/b_addr    : read request
//   b_rdata        : registered read data (valid the cycle after b_re)
module ram_dual_port #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     a_we,
  input  logic [$clog2(DEPTH)-1:0] a_addr,
  input  logic [WIDTH-1:0]         a_wdata,
  input  logic                     b_re,
  input  logic [$clog2(DEPTH)-1:0] b_addr,
  output logic [WIDTH-1:0]         b_rdata
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (a_we) mem_q[a_addr] <= a_wdata;
    if (b_re) rdata_q <= mem_q[b_addr];
  end

  assign b_rdata = rdata_q;
endmodule

// File: rtl/chained_input_buffer.sv
// Chained input buffer: a show-ahead queue of N-lane vectors, each tagged
// with its EOF bit and the chain it belongs to. The chain counter advances
// on every accepted EOF and wraps at a run-time programmable num_chains.
//   clk, reset : clock, synchronous active-high reset
//   bus        : chained_input_buffer_if.slave (write side, config, head
//                of queue, full/overflow/occupancy status)
// Datapath: RAM (write at edge T) -> RAM read register -> output register,
// so a write into an empty queue shows on valid_out after edge T+2.
module chained_input_buffer
  import lebug_pkg::*;
#(
  parameter int          N          = DEF_N,
  parameter int          DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int          IB_DEPTH   = DEF_IB_DEPTH,
  parameter int          MAX_CHAINS = DEF_MAX_CHAINS,
  parameter logic [7:0]  CONFIG_ID  = DEF_CONFIG_ID
) (
  input logic                   clk,
  input logic                   reset,
  chained_input_buffer_if.slave bus
);
  localparam int VW = N * DATA_WIDTH;
  localparam int CW = $clog2(MAX_CHAINS);
  localparam int AW = $clog2(IB_DEPTH);
  localparam int OW = AW + 1;
  localparam int EW = VW + 1 + CW;

  // Same layout as lebug_pkg::entry_t, sized by this instance's parameters.
  typedef struct packed {
    logic [VW-1:0] vector;
    logic          eof;
    logic [CW-1:0] chain_id;
  } rec_t;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OW-1:0] ram_cnt_q, ram_cnt_d, occ_q, occ_d;
  logic          ram_vld_q, ram_vld_d;
  logic          out_vld_q, out_vld_d;
  logic          out_eof_q, out_eof_d;
  logic [CW-1:0] out_chain_q, out_chain_d;
  logic [VW-1:0] out_vec_q, out_vec_d;
  logic          ovf_q, ovf_d;
  logic [CW-1:0] chain_q, chain_d;
  logic [CW:0]   nchain_q, nchain_d;

  logic          full, wr_try, wr_acc, deq, out_load, rd_en;
  logic [CW:0]   chain_inc;
  rec_t          wr_rec, ram_rec;
  logic [EW-1:0] ram_rdata;

  // Full is judged on the registered occupancy, so a dequeue in the same
  // cycle does not open room for a write.
  assign full   = (occ_q == OW'(IB_DEPTH));
  assign wr_try = bus.enqueue & bus.tracing;
  assign wr_acc = wr_try & ~full;
  assign deq    = out_vld_q & bus.dequeue_in;
  // Move the fetched entry forward whenever the output register is free or
  // being emptied; refetch whenever the read register is free or moving.
  assign out_load = ram_vld_q & (~out_vld_q | deq);
  assign rd_en    = (ram_cnt_q != '0) & (~ram_vld_q | out_load);

  assign wr_rec    = '{vector: bus.vector_in, eof: bus.eof_in, chain_id: chain_q};
  assign ram_rec   = ram_rdata;
  assign chain_inc = {1'b0, chain_q} + (CW+1)'(1);

  ram_dual_port #(.WIDTH(EW), .DEPTH(IB_DEPTH)) u_ram (
    .clk     (clk),
    .a_we    (wr_acc),
    .a_addr  (wr_ptr_q),
    .a_wdata (wr_rec),
    .b_re    (rd_en),
    .b_addr  (rd_ptr_q),
    .b_rdata (ram_rdata)
  );

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    ram_cnt_d   = ram_cnt_q + OW'(wr_acc) - OW'(rd_en);
    occ_d       = occ_q + OW'(wr_acc) - OW'(deq);
    ram_vld_d   = ram_vld_q;
    out_vld_d   = out_vld_q;
    out_eof_d   = out_eof_q;
    out_chain_d = out_chain_q;
    out_vec_d   = out_vec_q;
    ovf_d       = ovf_q | (wr_try & full);
    chain_d     = chain_q;
    nchain_d    = nchain_q;

    if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_en)  rd_ptr_d = rd_ptr_q + AW'(1);

    if (rd_en)         ram_vld_d = 1'b1;
    else if (out_load) ram_vld_d = 1'b0;

    if (out_load) begin
      out_vld_d   = 1'b1;
      out_eof_d   = ram_rec.eof;
      out_chain_d = ram_rec.chain_id;
      out_vec_d   = ram_rec.vector;
    end else if (deq) begin
      out_vld_d   = 1'b0;
    end

    if (wr_acc && bus.eof_in)
      chain_d = (chain_inc >= nchain_q) ? '0 : chain_inc[CW-1:0];

    // Config wins over the increment; the write above already captured
    // the pre-update counter in wr_rec.
    if (bus.configId == CONFIG_ID) begin
      nchain_d = (CW+1)'(clamp_chains(bus.configData, MAX_CHAINS));
      chain_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ram_cnt_q   <= '0;
      occ_q       <= '0;
      ram_vld_q   <= 1'b0;
      out_vld_q   <= 1'b0;
      out_eof_q   <= 1'b0;
      out_chain_q <= '0;
      ovf_q       <= 1'b0;
      chain_q     <= '0;
      nchain_q    <= (CW+1)'(MAX_CHAINS);
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ram_cnt_q   <= ram_cnt_d;
      occ_q       <= occ_d;
      ram_vld_q   <= ram_vld_d;
      out_vld_q   <= out_vld_d;
      out_eof_q   <= out_eof_d;
      out_chain_q <= out_chain_d;
      ovf_q       <= ovf_d;
      chain_q     <= chain_d;
      nchain_q    <= nchain_d;
    end
  end

  // Head vector payload is don't-care while invalid, so it is not reset.
  always_ff @(posedge clk) begin
    out_vec_q <= out_vec_d;
  end

  assign bus.valid_out     = out_vld_q;
  assign bus.eof_out       = out_eof_q;
  assign bus.vector_out    = out_vec_q;
  assign bus.chainId_out   = out_chain_q;
  assign bus.full_out      = full;
  assign bus.overflow_out  = ovf_q;
  assign bus.occupancy_out = occ_q;
endmodule

// File: tb/tb_chained_input_buffer.sv
module tb_chained_input_buffer;
  localparam int         N          = 8;
  localparam int         DATA_WIDTH = 32;
  localparam int         IB_DEPTH   = 4;
  localparam int         MAX_CHAINS = 4;
  localparam logic [7:0] CONFIG_ID  = 8'd1;
  localparam int         VW         = N * DATA_WIDTH;

  logic clk;
  logic reset;

  chained_input_buffer_if #(.N(N), .DATA_WIDTH(DATA_WIDTH), .IB_DEPTH(IB_DEPTH),
                            .MAX_CHAINS(MAX_CHAINS)) bus ();

  chained_input_buffer #(.N(N), .DATA_WIDTH(DATA_WIDTH), .IB_DEPTH(IB_DEPTH),
                         .MAX_CHAINS(MAX_CHAINS), .CONFIG_ID(CONFIG_ID)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int errors = 0;
  int checks = 0;

  // Reference model: an ordered list of accepted entries, each stamped with
  // the edge number at which it was written.
  typedef struct {
    logic [VW-1:0] vec;
    logic          eof;
    int            chain;
    int            t;
  } mentry_t;

  mentry_t mq[$];
  int      m_chain = 0;
  int      m_nch   = MAX_CHAINS;
  bit      m_ovf   = 0;
  int      cyc     = 0;

  int obs_chain[$];
  int obs_data[$];
  int got_q[$];
  int exp_q[$];

  typedef struct {
    int enq; int deq; int d; int vld; int xd; int occ; int full; int ovf;
  } vec_t;
  vec_t tbl[23];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_vec(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [VW-1:0] mkvec(input logic [7:0] d);
    logic [VW-1:0] v;
    v = '0;
    for (int l = 0; l < N; l++) v[l*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(d);
    return v;
  endfunction

  function automatic logic [VW-1:0] rndvec();
    logic [VW-1:0] v;
    for (int l = 0; l < N; l++) v[l*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'($urandom);
    return v;
  endfunction

  function automatic bit model_visible();
    if (mq.size() == 0) return 0;
    return cyc >= mq[0].t + 2;
  endfunction

  task automatic model_edge();
    bit      full_m, deq_m, acc;
    int      raw;
    mentry_t e;
    if (reset) begin
      mq.delete();
      m_chain = 0;
      m_nch   = MAX_CHAINS;
      m_ovf   = 0;
    end else begin
      full_m = (mq.size() == IB_DEPTH);
      deq_m  = model_visible() && bus.dequeue_in;
      acc    = bus.enqueue && bus.tracing && !full_m;
      if (bus.enqueue && bus.tracing && full_m) m_ovf = 1;
      if (deq_m) void'(mq.pop_front());
      if (acc) begin
        e.vec   = bus.vector_in;
        e.eof   = bus.eof_in;
        e.chain = m_chain;
        e.t     = cyc + 1;
        mq.push_back(e);
        if (bus.eof_in) m_chain = (m_chain + 1) % m_nch;
      end
      if (bus.configId == CONFIG_ID) begin
        raw = int'(bus.configData);
        m_nch   = (raw < 1) ? 1 : ((raw > MAX_CHAINS) ? MAX_CHAINS : raw);
        m_chain = 0;
      end
    end
    cyc++;
  endtask

  task automatic check_model();
    bit v;
    v = model_visible();
    chk("m_valid", bus.valid_out, v);
    chk("m_occupancy", bus.occupancy_out, mq.size());
    chk("m_full", bus.full_out, mq.size() == IB_DEPTH);
    chk("m_overflow", bus.overflow_out, m_ovf);
    if (v) begin
      chk_vec("m_vector", bus.vector_out, mq[0].vec);
      chk("m_eof", bus.eof_out, mq[0].eof);
      chk("m_chain", bus.chainId_out, mq[0].chain);
    end
  endtask

  // Inputs are already set by the caller; record what the consumer takes,
  // advance the model and the DUT by one edge, then compare.
  task automatic step();
    if (bus.valid_out && bus.dequeue_in) begin
      obs_chain.push_back(int'(bus.chainId_out));
      obs_data.push_back(int'(bus.vector_out[7:0]));
    end
    model_edge();
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic put(input bit en, input bit eof, input logic [7:0] d, input bit deq);
    reset          = 1'b0;
    bus.enqueue    = en;
    bus.eof_in     = eof;
    bus.tracing    = 1'b1;
    bus.configId   = 8'd0;
    bus.configData = 8'd0;
    bus.vector_in  = mkvec(d);
    bus.dequeue_in = deq;
    step();
  endtask

  task automatic cfg(input logic [7:0] d);
    bus.enqueue    = 1'b0;
    bus.configId   = CONFIG_ID;
    bus.configData = d;
    bus.dequeue_in = 1'b1;
    step();
    bus.configId   = 8'd0;
  endtask

  task automatic cmp_q(input string nm);
    chk({nm, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s_%0d", nm, i), got_q[i], exp_q[i]);
  endtask

  initial begin
    int v;
    int guard;
    int maxocc;

    //            enq deq  d     vld xd    occ full ovf
    tbl[0]  = '{1, 1, 'hA5, 0, 'h00, 1, 0, 0};
    tbl[1]  = '{0, 1, 'h00, 0, 'h00, 1, 0, 0};
    tbl[2]  = '{0, 1, 'h00, 1, 'hA5, 1, 0, 0};
    tbl[3]  = '{0, 1, 'h00, 0, 'h00, 0, 0, 0};
    tbl[4]  = '{0, 0, 'h00, 0, 'h00, 0, 0, 0};
    tbl[5]  = '{1, 0, 'h01, 0, 'h00, 1, 0, 0};
    tbl[6]  = '{1, 0, 'h02, 0, 'h00, 2, 0, 0};
    tbl[7]  = '{1, 0, 'h03, 1, 'h01, 3, 0, 0};
    tbl[8]  = '{1, 0, 'h04, 1, 'h01, 4, 1, 0};
    tbl[9]  = '{1, 0, 'h05, 1, 'h01, 4, 1, 1};
    tbl[10] = '{0, 1, 'h00, 1, 'h02, 3, 0, 1};
    tbl[11] = '{0, 1, 'h00, 1, 'h03, 2, 0, 1};
    tbl[12] = '{0, 1, 'h00, 1, 'h04, 1, 0, 1};
    tbl[13] = '{0, 1, 'h00, 0, 'h00, 0, 0, 1};
    tbl[14] = '{1, 0, 'h06, 0, 'h00, 1, 0, 1};
    tbl[15] = '{1, 0, 'h07, 0, 'h00, 2, 0, 1};
    tbl[16] = '{1, 0, 'h08, 1, 'h06, 3, 0, 1};
    tbl[17] = '{1, 0, 'h09, 1, 'h06, 4, 1, 1};
    tbl[18] = '{1, 1, 'h0A, 1, 'h07, 3, 0, 1};
    tbl[19] = '{1, 1, 'h0B, 1, 'h08, 3, 0, 1};
    tbl[20] = '{0, 1, 'h00, 1, 'h09, 2, 0, 1};
    tbl[21] = '{0, 1, 'h00, 1, 'h0B, 1, 0, 1};
    tbl[22] = '{0, 1, 'h00, 0, 'h00, 0, 0, 1};

    reset          = 1'b1;
    bus.enqueue    = 1'b0;
    bus.eof_in     = 1'b0;
    bus.tracing    = 1'b1;
    bus.configId   = 8'd0;
    bus.configData = 8'd0;
    bus.vector_in  = '0;
    bus.dequeue_in = 1'b0;
    step();
    step();
    reset = 1'b0;
    chk("rst_valid", bus.valid_out, 0);
    chk("rst_occ", bus.occupancy_out, 0);
    chk("rst_full", bus.full_out, 0);
    chk("rst_ovf", bus.overflow_out, 0);
    chk("rst_eof", bus.eof_out, 0);
    chk("rst_chain", bus.chainId_out, 0);

    // Single-write latency, fill/overflow/drain, full+dequeue drop.
    for (int i = 0; i < 23; i++) begin
      put(tbl[i].enq != 0, 1'b0, 8'(tbl[i].d), tbl[i].deq != 0);
      chk($sformatf("tbl%0d_valid", i), bus.valid_out, tbl[i].vld);
      chk($sformatf("tbl%0d_occ", i), bus.occupancy_out, tbl[i].occ);
      chk($sformatf("tbl%0d_full", i), bus.full_out, tbl[i].full);
      chk($sformatf("tbl%0d_ovf", i), bus.overflow_out, tbl[i].ovf);
      if (tbl[i].vld != 0) begin
        chk_vec($sformatf("tbl%0d_vec", i), bus.vector_out, mkvec(8'(tbl[i].xd)));
        chk($sformatf("tbl%0d_chain", i), bus.chainId_out, 0);
        chk($sformatf("tbl%0d_eof", i), bus.eof_out, 0);
      end
    end

    // Three chains, four two-vector frames.
    cfg(8'd3);
    obs_chain.delete();
    for (int i = 0; i < 8; i++) put(1'b1, (i % 2) == 1, 8'(i + 1), 1'b1);
    for (int i = 0; i < 5; i++) put(1'b0, 1'b0, 8'd0, 1'b1);
    got_q = obs_chain;
    exp_q = '{0, 0, 1, 1, 2, 2, 0, 0};
    cmp_q("chains3");

    // configData=0 clamps to one chain.
    cfg(8'd0);
    obs_chain.delete();
    for (int i = 0; i < 4; i++) put(1'b1, 1'b1, 8'(i + 16), 1'b1);
    for (int i = 0; i < 5; i++) put(1'b0, 1'b0, 8'd0, 1'b1);
    got_q = obs_chain;
    exp_q = '{0, 0, 0, 0};
    cmp_q("clamp_lo");

    // configData=9 clamps to MAX_CHAINS.
    cfg(8'd9);
    obs_chain.delete();
    for (int i = 0; i < 5; i++) put(1'b1, 1'b1, 8'(i + 32), 1'b1);
    for (int i = 0; i < 5; i++) put(1'b0, 1'b0, 8'd0, 1'b1);
    got_q = obs_chain;
    exp_q = '{0, 1, 2, 3, 0};
    cmp_q("clamp_hi");

    // Write in the config cycle keeps the old tag; next write starts at 0.
    obs_chain.delete();
    bus.enqueue    = 1'b1;
    bus.eof_in     = 1'b1;
    bus.vector_in  = mkvec(8'h40);
    bus.configId   = CONFIG_ID;
    bus.configData = 8'd4;
    bus.dequeue_in = 1'b1;
    step();
    put(1'b1, 1'b0, 8'h41, 1'b1);
    for (int i = 0; i < 5; i++) put(1'b0, 1'b0, 8'd0, 1'b1);
    got_q = obs_chain;
    exp_q = '{1, 0};
    cmp_q("cfg_same_cycle");

    // Reset with entries queued and overflow set; reset beats enqueue/config.
    for (int i = 0; i < 3; i++) put(1'b1, 1'b1, 8'(8'h21 + i), 1'b0);
    chk("pre_rst_occ", bus.occupancy_out, 3);
    reset          = 1'b1;
    bus.enqueue    = 1'b1;
    bus.configId   = CONFIG_ID;
    bus.configData = 8'd2;
    bus.dequeue_in = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_rst_valid", bus.valid_out, 0);
    chk("mid_rst_occ", bus.occupancy_out, 0);
    chk("mid_rst_ovf", bus.overflow_out, 0);
    chk("mid_rst_full", bus.full_out, 0);
    put(1'b1, 1'b0, 8'h31, 1'b0);
    put(1'b0, 1'b0, 8'h00, 1'b0);
    put(1'b0, 1'b0, 8'h00, 1'b0);
    chk("post_rst_valid", bus.valid_out, 1);
    chk("post_rst_chain", bus.chainId_out, 0);
    chk_vec("post_rst_vec", bus.vector_out, mkvec(8'h31));
    put(1'b0, 1'b0, 8'h00, 1'b1);

    // tracing=0 ignores enqueue: no store, no overflow even when full.
    for (int i = 0; i < 4; i++) put(1'b1, 1'b0, 8'(8'h50 + i), 1'b0);
    bus.tracing = 1'b0;
    step();
    step();
    chk("notrace_ovf", bus.overflow_out, 0);
    chk("notrace_occ", bus.occupancy_out, 4);
    put(1'b1, 1'b0, 8'h5F, 1'b0);
    chk("trace_ovf", bus.overflow_out, 1);
    for (int i = 0; i < 6; i++) put(1'b0, 1'b0, 8'd0, 1'b1);
    bus.tracing = 1'b0;
    bus.enqueue = 1'b1;
    step();
    chk("notrace_empty_occ", bus.occupancy_out, 0);

    // Twelve writes under random consumer stalls.
    obs_data.delete();
    v = 1;
    guard = 0;
    maxocc = 0;
    while (v <= 12 && guard < 400) begin
      if (mq.size() < IB_DEPTH && ($urandom % 4) != 0) begin
        put(1'b1, 1'b0, 8'(v), 1'($urandom % 2));
        v++;
      end else begin
        put(1'b0, 1'b0, 8'd0, 1'($urandom % 2));
      end
      if (int'(bus.occupancy_out) > maxocc) maxocc = int'(bus.occupancy_out);
      guard++;
    end
    chk("stall_all_written", v, 13);
    for (int i = 0; i < 8; i++) put(1'b0, 1'b0, 8'd0, 1'b1);
    chk("stall_max_occ_le_depth", maxocc <= IB_DEPTH, 1);
    got_q = obs_data;
    exp_q.delete();
    for (int i = 1; i <= 12; i++) exp_q.push_back(i);
    cmp_q("stall_order");

    // Broad random traffic against the model.
    for (int i = 0; i < 800; i++) begin
      reset          = (($urandom % 100) == 0);
      bus.enqueue    = (($urandom % 10) < 6);
      bus.tracing    = (($urandom % 20) != 0);
      bus.eof_in     = (($urandom % 10) < 3);
      bus.vector_in  = rndvec();
      bus.dequeue_in = (($urandom % 10) < 6);
      bus.configId   = (($urandom % 25) == 0) ? CONFIG_ID : 8'($urandom_range(2, 255));
      bus.configData = 8'($urandom_range(0, 10));
      step();
    end
    reset = 1'b0;
    for (int i = 0; i < 8; i++) put(1'b0, 1'b0, 8'd0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
